seg_scan_rx: RTL and testbench
==============================

Name: seg_scan_rx

Overview:
Reader for a multiplexed active-low 7-segment display bus. It watches the segment lines and the digit-select lines driven by the hex-to-segment encoder and scan logic, and recovers each displayed digit as a 4-bit value once the bus has been stable long enough. It also reports blank digits and non-hex segment patterns. It sits on the checker/loopback side of the display path, so display output can be verified or echoed back into logic.

Parameters:
DIGITS, 8, number of scanned digit positions (1..8).
STABLE_CYCLES, 4, consecutive identical samples required before a capture (>=1).

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset
seg_i  input  7  segment lines, active-low; bit0=a … bit6=g
an_i  input  DIGITS  digit selects, active-low, expected one-hot-low
value_o  output  4*DIGITS  recovered nibbles; digit i in bits [4i+3:4i]
valid_o  output  DIGITS  digit i holds a decoded hex value
blank_o  output  DIGITS  digit i last captured as all-off (7'h7F)
err_o  output  DIGITS  digit i last captured as a non-hex, non-blank pattern
upd_o  output  1  one-cycle strobe on each capture
upd_idx_o  output  3  digit index of the capture flagged by upd_o

Behaviour:
- Reset (clk edge with rst_n=0) clears the following: value_o=0, valid_o=0, blank_o=0, err_o=0, upd_o=0, upd_idx_o=0, sample registers, stability counter, FSM state=IDLE.
- Input stage: seg_i and an_i are registered every cycle into one sample stage. All decisions use the registered sample.
- Selection is legal only when exactly one bit of the sampled an is 0. No bits low or more than one bit low is an illegal selection.
- FSM states:
  - IDLE: legal selection -> SETTLE, counter=1.
  - SETTLE: sample equal to previous sample -> counter+1. When counter reaches STABLE_CYCLES -> CAPTURE. A changed sample -> counter=1 and stay in SETTLE. Illegal selection -> IDLE.
  - CAPTURE: single cycle. Writes digit idx and pulses upd_o on the next edge, then -> HOLD.
  - HOLD: stays while the sample is unchanged, so there is exactly one capture per stable window. Any change -> SETTLE with counter=1 if legal, else IDLE.
- Latency: once seg_i/an_i are held constant and legal, upd_o is high for exactly one cycle, STABLE_CYCLES+2 rising edges after the first edge that samples the new values.
- Decode table (seg code -> nibble), identical to the encoder's:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E (hex, 7 bits)
- Capture result for digit idx:
  - Hit: value nibble updated, valid=1, blank=0, err=0.
  - 7'h7F: blank=1, valid=0, err=0, nibble retained.
  - Other pattern: err=1, valid=0, blank=0, nibble retained.
- Other digits are never touched by a capture.
- upd_idx_o = index of the low bit of an, zero-extended.
- Reset mid-SETTLE or mid-CAPTURE: the capture is abandoned and no upd_o pulse is issued.
- Scan faster than STABLE_CYCLES per digit: no captures occur. This is not an error.

Optional Feature:
SEG_SCAN_RX_DP_EN:
- When defined, adds port dp_i (input, 1, active-low decimal point) and port dp_o (output, DIGITS).
- dp_i is sampled and included in the stability compare.
- On any capture, dp_o[idx] = ~dp_i sample. dp_o resets to 0.
- When undefined, neither port exists and the decimal point is ignored.

Decomposition:
- Package seg_pkg holds:
  - 16-entry localparam array of segment codes indexed by nibble.
  - SEG_BLANK = 7'h7F.
  - State enum IDLE/SETTLE/CAPTURE/HOLD.
- The encoder and this block both take codes from seg_pkg.
- Sub-module seg_decode (combinational): seg[6:0] -> nibble[3:0], hit, blank. Instantiated once.
- FSM, counter and per-digit storage stay in seg_scan_rx.

Test Plan:
1. Reset, then an_i=8'hFE, seg_i=7'h24 held 10 cycles -> one upd_o pulse at the required latency, upd_idx_o=0, value_o[3:0]=2, valid_o[0]=1.
2. Cycle digits 0..7 showing 0x1..0x8, each held 8 cycles -> value_o=32'h87654321, valid_o=8'hFF, exactly 8 upd_o pulses.
3. Digit 3 with seg_i=7'h7F, then with 7'h55 -> first capture blank_o[3]=1; second err_o[3]=1, valid_o[3]=0, nibble unchanged.
4. an_i=8'hFC (two low) or 8'hFF for 20 cycles -> no upd_o, no output change.
5. seg_i toggled every 2 cycles with STABLE_CYCLES=4 -> no capture. Then held -> single capture of the final value.
6. Assert rst_n=0 during SETTLE of digit 5 -> no upd_o, all outputs 0. Recapture proceeds normally after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-low segment codes indexed by nibble,
// the all-off pattern, and the scan-reader FSM state encoding.
package seg_pkg;

   localparam logic [6:0] SEG_CODES [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_e;

endpackage

// File: rtl/seg_decode.sv
// Combinational reverse lookup of an active-low segment pattern into its hex
// nibble, flagging table hits and the all-off (blank) pattern.
module seg_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] nibble_o,
   output logic       hit_o,
   output logic       blank_o
);

   always_comb begin
      nibble_o = 4'd0;
      hit_o    = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (seg_i == SEG_CODES[i]) begin
            nibble_o = 4'(i);
            hit_o    = 1'b1;
         end
      end
      blank_o = (seg_i == SEG_BLANK);
   end

endmodule

// File: rtl/seg_scan_rx.sv
// Multiplexed 7-segment bus reader: captures each digit once its select and
// segment lines have been stable. Optional decimal point via SEG_SCAN_RX_DP_EN.
module seg_scan_rx
   import seg_pkg::*;
#(
   parameter int DIGITS        = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            seg_i,
   input  logic [DIGITS-1:0]     an_i,
`ifdef SEG_SCAN_RX_DP_EN
   input  logic                  dp_i,
   output logic [DIGITS-1:0]     dp_o,
`endif
   output logic [4*DIGITS-1:0]   value_o,
   output logic [DIGITS-1:0]     valid_o,
   output logic [DIGITS-1:0]     blank_o,
   output logic [DIGITS-1:0]     err_o,
   output logic                  upd_o,
   output logic [2:0]            upd_idx_o
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   function automatic logic [2:0] low_idx(input logic [DIGITS-1:0] an);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!an[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   logic [6:0]        seg_q, seg_d, seg_prev_q, seg_prev_d;
   logic [DIGITS-1:0] an_q, an_d, an_prev_q, an_prev_d;
`ifdef SEG_SCAN_RX_DP_EN
   logic              dp_q, dp_d, dp_prev_q, dp_prev_d;
`endif
   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              upd_q, upd_d;
   logic [2:0]        upd_idx_q, upd_idx_d;

   logic              changed, legal, cap_en;
   logic [2:0]        cap_idx;
   logic [3:0]        dec_nibble;
   logic              dec_hit, dec_blank;

   always_comb begin
      seg_d      = seg_i;
      an_d       = an_i;
      seg_prev_d = seg_q;
      an_prev_d  = an_q;
`ifdef SEG_SCAN_RX_DP_EN
      dp_d       = dp_i;
      dp_prev_d  = dp_q;
`endif
   end

   always_comb begin
      int zeros;
      zeros = 0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!an_q[i]) zeros = zeros + 1;
      end
      legal   = (zeros == 1);
      changed = (seg_q != seg_prev_q) || (an_q != an_prev_q);
`ifdef SEG_SCAN_RX_DP_EN
      changed = changed || (dp_q != dp_prev_q);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (legal) begin
               state_d = SETTLE;
               cnt_d   = CW'(1);
            end
         end
         SETTLE: begin
            if (!legal) begin
               state_d = IDLE;
            end else if (changed) begin
               cnt_d = CW'(1);
            end else if (cnt_q == CW'(STABLE_CYCLES)) begin
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         // CAPTURE and HOLD share the same exit rule on a changed sample.
         CAPTURE, HOLD: begin
            if (changed) begin
               state_d = legal ? SETTLE : IDLE;
               cnt_d   = CW'(1);
            end else begin
               state_d = HOLD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The previous sample is the one proven stable when CAPTURE is entered.
   always_comb begin
      cap_en    = (state_q == CAPTURE);
      cap_idx   = low_idx(an_prev_q);
      upd_d     = cap_en;
      upd_idx_d = cap_en ? cap_idx : upd_idx_q;
   end

   seg_decode u_dec (
      .seg_i    (seg_prev_q),
      .nibble_o (dec_nibble),
      .hit_o    (dec_hit),
      .blank_o  (dec_blank)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_q      <= '0;
         an_q       <= '0;
         seg_prev_q <= '0;
         an_prev_q  <= '0;
`ifdef SEG_SCAN_RX_DP_EN
         dp_q       <= 1'b0;
         dp_prev_q  <= 1'b0;
`endif
         upd_q      <= 1'b0;
         upd_idx_q  <= 3'd0;
      end else begin
         seg_q      <= seg_d;
         an_q       <= an_d;
         seg_prev_q <= seg_prev_d;
         an_prev_q  <= an_prev_d;
`ifdef SEG_SCAN_RX_DP_EN
         dp_q       <= dp_d;
         dp_prev_q  <= dp_prev_d;
`endif
         upd_q      <= upd_d;
         upd_idx_q  <= upd_idx_d;
      end
   end

   assign upd_o     = upd_q;
   assign upd_idx_o = upd_idx_q;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
      logic [3:0] val_q, val_d;
      logic       valid_q, valid_d, blank_q, blank_d, err_q, err_d;
      logic       sel;
`ifdef SEG_SCAN_RX_DP_EN
      logic       dpo_q, dpo_d;
`endif

      always_comb begin
         sel     = cap_en && (cap_idx == 3'(gi));
         val_d   = val_q;
         valid_d = valid_q;
         blank_d = blank_q;
         err_d   = err_q;
`ifdef SEG_SCAN_RX_DP_EN
         dpo_d   = dpo_q;
         if (sel) dpo_d = ~dp_prev_q;
`endif
         if (sel) begin
            valid_d = dec_hit;
            blank_d = !dec_hit && dec_blank;
            err_d   = !dec_hit && !dec_blank;
            if (dec_hit) val_d = dec_nibble;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            val_q   <= 4'd0;
            valid_q <= 1'b0;
            blank_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef SEG_SCAN_RX_DP_EN
            dpo_q   <= 1'b0;
`endif
         end else begin
            val_q   <= val_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            err_q   <= err_d;
`ifdef SEG_SCAN_RX_DP_EN
            dpo_q   <= dpo_d;
`endif
         end
      end

      assign value_o[4*gi +: 4] = val_q;
      assign valid_o[gi]        = valid_q;
      assign blank_o[gi]        = blank_q;
      assign err_o[gi]          = err_q;
`ifdef SEG_SCAN_RX_DP_EN
      assign dp_o[gi]           = dpo_q;
`endif
   end

endmodule

// File: tb/tb_seg_scan_rx.sv
// Directed bench for seg_scan_rx (DIGITS=8, STABLE_CYCLES=4); connects the
// decimal-point ports only when SEG_SCAN_RX_DP_EN is defined.
module tb_seg_scan_rx;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg_i;
   logic [7:0]  an_i;
   logic [31:0] value_o;
   logic [7:0]  valid_o, blank_o, err_o;
   logic        upd_o;
   logic [2:0]  upd_idx_o;
`ifdef SEG_SCAN_RX_DP_EN
   logic        dp_i = 1'b1;
   logic [7:0]  dp_o;
`endif

   logic [6:0] code [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int upd_cnt  = 0;
   int upd_cyc  = -1;
   int c0;
   logic [2:0] last_idx = 3'd0;

   seg_scan_rx #(.DIGITS(8), .STABLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .seg_i     (seg_i),
      .an_i      (an_i),
`ifdef SEG_SCAN_RX_DP_EN
      .dp_i      (dp_i),
      .dp_o      (dp_o),
`endif
      .value_o   (value_o),
      .valid_o   (valid_o),
      .blank_o   (blank_o),
      .err_o     (err_o),
      .upd_o     (upd_o),
      .upd_idx_o (upd_idx_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      if (upd_o) begin
         upd_cnt++;
         upd_cyc  = cyc;
         last_idx = upd_idx_o;
         $display("capture @%0d idx=%0d value=%h valid=%h blank=%h err=%h",
                  cyc, upd_idx_o, value_o, valid_o, blank_o, err_o);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic [7:0] an, input logic [6:0] seg, input int n);
      an_i  = an;
      seg_i = seg;
      repeat (n) @(negedge clk);
      $display("step an=%h seg=%h cycles=%0d -> value=%h valid=%h blank=%h err=%h upd_cnt=%0d",
               an, seg, n, value_o, valid_o, blank_o, err_o, upd_cnt);
   endtask

   initial begin
      rst_n = 1'b0;
      an_i  = 8'hFF;
      seg_i = 7'h7F;
      repeat (3) @(negedge clk);
      check("reset_value", value_o, 32'h0);
      check("reset_valid", {24'h0, valid_o}, 32'h0);
      check("reset_blank_err", {16'h0, blank_o, err_o}, 32'h0);
      check("reset_upd", {28'h0, upd_o, upd_idx_o}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: single digit, latency
      upd_cnt = 0;
      c0 = cyc;
      hold(8'hFE, code[2], 10);
      check("t1_upd_count", upd_cnt, 1);
      check("t1_latency", upd_cyc, c0 + 1 + S + 2);
      check("t1_idx", {29'h0, last_idx}, 32'h0);
      check("t1_nibble", {28'h0, value_o[3:0]}, 32'h2);
      check("t1_valid", {31'h0, valid_o[0]}, 32'h1);

      // 2: scan all digits
      upd_cnt = 0;
      for (int d = 0; d < 8; d++) begin
         logic [7:0] an;
         an = ~(8'h01 << d);
         hold(an, code[d+1], 8);
      end
      check("t2_upd_count", upd_cnt, 8);
      check("t2_value", value_o, 32'h87654321);
      check("t2_valid", {24'h0, valid_o}, 32'hFF);
      check("t2_last_idx", {29'h0, last_idx}, 32'h7);
      check("t2_blank_err", {16'h0, blank_o, err_o}, 32'h0);

      // 3: blank, then non-hex on digit 3
      upd_cnt = 0;
      hold(8'hF7, 7'h7F, 8);
      check("t3_blank", {24'h0, blank_o}, 32'h08);
      check("t3_blank_valid", {24'h0, valid_o}, 32'hF7);
      check("t3_blank_err", {24'h0, err_o}, 32'h00);
      check("t3_blank_value", value_o, 32'h87654321);
      hold(8'hF7, 7'h55, 8);
      check("t3_err", {24'h0, err_o}, 32'h08);
      check("t3_err_blank", {24'h0, blank_o}, 32'h00);
      check("t3_err_valid", {24'h0, valid_o}, 32'hF7);
      check("t3_err_value", value_o, 32'h87654321);
      check("t3_upd_count", upd_cnt, 2);
      check("t3_idx", {29'h0, last_idx}, 32'h3);

      // 4: illegal selections
      upd_cnt = 0;
      hold(8'hFC, code[5], 20);
      hold(8'hFF, code[5], 20);
      check("t4_upd_count", upd_cnt, 0);
      check("t4_value", value_o, 32'h87654321);
      check("t4_flags", {valid_o, blank_o, err_o, 8'h0}, 32'hF7000800);

      // 5: fast toggle, then hold
      upd_cnt = 0;
      for (int k = 0; k < 10; k++) hold(8'hFB, (k % 2 == 0) ? code[0] : code[9], 2);
      check("t5_no_capture", upd_cnt, 0);
      hold(8'hFB, code[10], 10);
      check("t5_upd_count", upd_cnt, 1);
      check("t5_idx", {29'h0, last_idx}, 32'h2);
      check("t5_value", value_o, 32'h87654A21);

      // 6: reset during SETTLE of digit 5
      upd_cnt = 0;
      hold(8'hDF, code[13], 3);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("t6_rst_value", value_o, 32'h0);
      check("t6_rst_flags", {8'h0, valid_o, blank_o, err_o}, 32'h0);
      check("t6_rst_upd", {31'h0, upd_o}, 32'h0);
      rst_n = 1'b1;
      c0 = cyc;
      hold(8'hDF, code[13], 10);
      check("t6_upd_count", upd_cnt, 1);
      check("t6_latency", upd_cyc, c0 + 1 + S + 2);
      check("t6_value", value_o, 32'h00D00000);
      check("t6_valid", {24'h0, valid_o}, 32'h20);
      check("t6_idx", {29'h0, last_idx}, 32'h5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
